cvt_frame_arbiter: RTL and testbench
====================================

Name: cvt_frame_arbiter

Overview:
- Shares one YCbCr-to-RGB converter between two YCbCr video sources, for example the raw path and the dehazed path.
- Arbitration is frame-granular. A source owns the converter from its vs rising edge through its vs falling edge. The converter pipeline is then drained before the next grant.
- Sits directly upstream of the converter's i_vs/i_hs/i_convert_en/i_y/i_cb/i_cr inputs.
- Emits a source tag aligned with the converter's output so downstream logic can demultiplex RGB.

Parameters:
- LATENCY, 3, converter input-to-output latency in cycles; sets drain length and tag delay.
- DATA_W, 8, width of each Y/Cb/Cr component.
- CNT_W, 16, width of each drop counter.

Ports:
- i_sys_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_src_mask  in  2  bit n=1 enables source n for grant
- i_s0_vs / i_s0_hs / i_s0_de  in  1 each  source 0 frame valid, line valid, pixel enable (all active-high)
- i_s0_y / i_s0_cb / i_s0_cr  in  DATA_W each  source 0 pixel
- i_s1_vs / i_s1_hs / i_s1_de  in  1 each  source 1 timing
- i_s1_y / i_s1_cb / i_s1_cr  in  DATA_W each  source 1 pixel
- o_cvt_vs / o_cvt_hs / o_cvt_en  out  1 each  to converter
- o_cvt_y / o_cvt_cb / o_cvt_cr  out  DATA_W each  to converter
- o_grant  out  2  one-hot current owner, 00 when none
- o_busy  out  1  state != IDLE
- o_out_sel  out  1  source index of the pixel leaving the converter
- o_out_vld  out  1  o_cvt_en delayed LATENCY cycles
- o_drop_cnt0 / o_drop_cnt1  out  CNT_W each  frames refused per source

Behaviour:
- Reset:
  - Applies to all outputs and state: outputs 0, state IDLE, round-robin pointer 0, tag/valid shift registers 0, counters 0.
  - Previous-vs registers reset to 1. A source already mid-frame at reset is not granted until vs falls and rises again.
- Edge detect: rise_n = i_sn_vs & ~vs_prev_n; vs_prev_n updates every cycle.
- States are IDLE, GRANT0, GRANT1, DRAIN.
- IDLE:
  - Eligible sources are those with rise_n=1 and i_src_mask[n]=1.
  - One eligible source: go to GRANTn.
  - Both eligible: grant the source selected by the pointer; count the other as dropped.
  - None eligible: stay in IDLE.
- GRANTn:
  - Stay while i_sn_vs=1.
  - On the cycle i_sn_vs=0, go to DRAIN and toggle the pointer to the other source.
  - i_src_mask changes are ignored mid-frame.
- DRAIN: hold LATENCY cycles, counted LATENCY-1 down to 0, then go to IDLE.
- Forwarding mux (registered, 1-cycle latency):
  - Keyed on the next-state grant. The pixel coincident with the vs rising edge is forwarded, and so is the cycle where vs falls, so the converter sees both edges.
  - When no grant, o_cvt_* = 0.
  - o_cvt_en = i_sn_de of the owner.
- o_grant is registered and equals the one-hot state in GRANTn; it is 00 in IDLE and DRAIN.
- Tag path:
  - LATENCY-deep shift registers carry the owner index and o_cvt_en.
  - o_out_sel / o_out_vld appear exactly LATENCY cycles after the matching o_cvt_* cycle.
- Drop counters:
  - Increment by 1 when an unmasked source has rise_n=1 and is not granted that cycle. This covers losing a simultaneous tie, the other source owning the converter, or DRAIN.
  - Saturate at 2^CNT_W-1.
  - Masked sources never count.
- A refused source is not granted later in that frame; it waits for its next rising edge.

Test Plan:
- Source 0 only, mask 11, frame vs high 20 cycles with de=1 → o_cvt_* mirrors source 0 at +1 cycle. o_grant=01 for 20 cycles, then DRAIN 3 cycles, then IDLE. o_out_sel=0 and o_out_vld high for 20 cycles starting 4 cycles after the first input pixel.
- Both vs rise the same cycle after reset → GRANT0, o_drop_cnt1=1. On the next simultaneous rise after DRAIN → GRANT1, o_drop_cnt0=1.
- Source 1 rises while GRANT0 is active, and again during DRAIN → source 1 is never forwarded, o_drop_cnt1=2, source 0 frame is undisturbed.
- Mask 10 with source 0 rising alone → no grant, drop counters unchanged. Clearing mask bit 1 mid-frame of source 1 → frame completes normally.
- Reset asserted mid-frame with i_s0_vs held high → after reset, o_cvt_*=0 and o_grant=00. Grant occurs only after vs goes low then high.
- With CNT_W=2, refuse source 1 five times → o_drop_cnt1 saturates at 3.

Source files
------------

// File: rtl/cvt_frame_arbiter_if.sv
// YCbCr video timing/pixel bundle shared by the two sources and the converter.
// master drives the bundle, slave observes it.
interface cvt_frame_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              vs;
    logic              hs;
    logic              de;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] cb;
    logic [DATA_W-1:0] cr;

    modport master (output vs, hs, de, y, cb, cr);
    modport slave  (input  vs, hs, de, y, cb, cr);
endinterface

// File: rtl/cvt_frame_arbiter.sv
// Frame-granular arbiter sharing one YCbCr-to-RGB converter between two sources.
// A source owns the converter from vs rise to vs fall, then the pipeline drains.
module cvt_frame_arbiter #(
    parameter int LATENCY = 3,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_src_mask,
    cvt_frame_arbiter_if.slave  i_s0,
    cvt_frame_arbiter_if.slave  i_s1,
    cvt_frame_arbiter_if.master o_cvt,
    output logic [1:0]         o_grant,
    output logic               o_busy,
    output logic               o_out_sel,
    output logic               o_out_vld,
    output logic [CNT_W-1:0]   o_drop_cnt0,
    output logic [CNT_W-1:0]   o_drop_cnt1
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;
    localparam int DCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic              vs_prev0_q, vs_prev1_q;
    logic [1:0]        elig;
    logic              fwd0, fwd1;
    logic              win0, win1;
    logic              drop0, drop1;

    logic              cvt_vs_q, cvt_hs_q, cvt_en_q, cvt_sel_q;
    logic [DATA_W-1:0] cvt_y_q, cvt_cb_q, cvt_cr_q;
    logic [1:0]        grant_q;
    logic [LATENCY-1:0] sel_sr_q, vld_sr_q;
    logic [CNT_W-1:0]  cnt0_q, cnt1_q;

    logic              mux_vs, mux_hs, mux_en;
    logic [DATA_W-1:0] mux_y, mux_cb, mux_cr;

    assign elig[0] = i_s0.vs & ~vs_prev0_q & i_src_mask[0];
    assign elig[1] = i_s1.vs & ~vs_prev1_q & i_src_mask[1];

    // Next-state: grant on eligible rise, hold for the frame, then drain.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (elig == 2'b11) begin
                    state_d = ptr_q ? GRANT1 : GRANT0;
                end else if (elig[0]) begin
                    state_d = GRANT0;
                end else if (elig[1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!i_s0.vs) begin
                    state_d = DRAIN;
                    drain_d = DCW'(LATENCY - 1);
                    ptr_d   = 1'b1;
                end
            end
            GRANT1: begin
                if (!i_s1.vs) begin
                    state_d = DRAIN;
                    drain_d = DCW'(LATENCY - 1);
                    ptr_d   = 1'b0;
                end
            end
            default: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
        endcase
    end

    // The owner keeps forwarding on its vs-fall cycle so the converter sees it.
    assign fwd0  = (state_d == GRANT0) | (state_q == GRANT0);
    assign fwd1  = (state_d == GRANT1) | (state_q == GRANT1);
    assign win0  = (state_q == IDLE) & (state_d == GRANT0);
    assign win1  = (state_q == IDLE) & (state_d == GRANT1);
    assign drop0 = elig[0] & ~win0;
    assign drop1 = elig[1] & ~win1;

    // Pixel mux selecting the owner, zero when nobody holds the converter.
    always_comb begin
        mux_vs = 1'b0;
        mux_hs = 1'b0;
        mux_en = 1'b0;
        mux_y  = '0;
        mux_cb = '0;
        mux_cr = '0;
        if (fwd0) begin
            mux_vs = i_s0.vs;
            mux_hs = i_s0.hs;
            mux_en = i_s0.de;
            mux_y  = i_s0.y;
            mux_cb = i_s0.cb;
            mux_cr = i_s0.cr;
        end else if (fwd1) begin
            mux_vs = i_s1.vs;
            mux_hs = i_s1.hs;
            mux_en = i_s1.de;
            mux_y  = i_s1.y;
            mux_cb = i_s1.cb;
            mux_cr = i_s1.cr;
        end
    end

    // Arbitration state, edge history and the registered converter drive.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            drain_q    <= '0;
            vs_prev0_q <= 1'b1;
            vs_prev1_q <= 1'b1;
            grant_q    <= 2'b00;
            cvt_vs_q   <= 1'b0;
            cvt_hs_q   <= 1'b0;
            cvt_en_q   <= 1'b0;
            cvt_sel_q  <= 1'b0;
            cvt_y_q    <= '0;
            cvt_cb_q   <= '0;
            cvt_cr_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            drain_q    <= drain_d;
            vs_prev0_q <= i_s0.vs;
            vs_prev1_q <= i_s1.vs;
            grant_q    <= {state_d == GRANT1, state_d == GRANT0};
            cvt_vs_q   <= mux_vs;
            cvt_hs_q   <= mux_hs;
            cvt_en_q   <= mux_en;
            cvt_sel_q  <= fwd1;
            cvt_y_q    <= mux_y;
            cvt_cb_q   <= mux_cb;
            cvt_cr_q   <= mux_cr;
        end
    end

    // Tag and valid follow the pixel through the converter's latency.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            sel_sr_q <= '0;
            vld_sr_q <= '0;
        end else begin
            sel_sr_q[0] <= cvt_sel_q;
            vld_sr_q[0] <= cvt_en_q;
            for (int i = 1; i < LATENCY; i++) begin
                sel_sr_q[i] <= sel_sr_q[i-1];
                vld_sr_q[i] <= vld_sr_q[i-1];
            end
        end
    end

    // Saturating counts of refused frame starts.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (drop0 && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
            if (drop1 && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign o_cvt.vs    = cvt_vs_q;
    assign o_cvt.hs    = cvt_hs_q;
    assign o_cvt.de    = cvt_en_q;
    assign o_cvt.y     = cvt_y_q;
    assign o_cvt.cb    = cvt_cb_q;
    assign o_cvt.cr    = cvt_cr_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q != IDLE);
    assign o_out_sel   = sel_sr_q[LATENCY-1];
    assign o_out_vld   = vld_sr_q[LATENCY-1];
    assign o_drop_cnt0 = cnt0_q;
    assign o_drop_cnt1 = cnt1_q;
endmodule

// File: tb/tb_cvt_frame_arbiter.sv
// Directed bench for cvt_frame_arbiter: vector table plus hand sequences.
// A second instance with 2-bit counters shares the stimulus.
module tb_cvt_frame_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  mask;
    logic [1:0]  grant, grant2;
    logic        busy, busy2;
    logic        osel, osel2;
    logic        ovld, ovld2;
    logic [15:0] dc0, dc1;
    logic [1:0]  nc0, nc1;
    int          total;
    int          bad;

    cvt_frame_arbiter_if #(.DATA_W(8)) s0_if ();
    cvt_frame_arbiter_if #(.DATA_W(8)) s1_if ();
    cvt_frame_arbiter_if #(.DATA_W(8)) cvt_if ();
    cvt_frame_arbiter_if #(.DATA_W(8)) cvt2_if ();

    cvt_frame_arbiter #(.LATENCY(3), .DATA_W(8), .CNT_W(16)) dut (
        .i_sys_clk  (clk),
        .i_rst      (rst),
        .i_src_mask (mask),
        .i_s0       (s0_if),
        .i_s1       (s1_if),
        .o_cvt      (cvt_if),
        .o_grant    (grant),
        .o_busy     (busy),
        .o_out_sel  (osel),
        .o_out_vld  (ovld),
        .o_drop_cnt0(dc0),
        .o_drop_cnt1(dc1)
    );

    cvt_frame_arbiter #(.LATENCY(3), .DATA_W(8), .CNT_W(2)) dut2 (
        .i_sys_clk  (clk),
        .i_rst      (rst),
        .i_src_mask (mask),
        .i_s0       (s0_if),
        .i_s1       (s1_if),
        .o_cvt      (cvt2_if),
        .o_grant    (grant2),
        .o_busy     (busy2),
        .o_out_sel  (osel2),
        .o_out_vld  (ovld2),
        .o_drop_cnt0(nc0),
        .o_drop_cnt1(nc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] msk;
        logic       v0, d0;
        logic [7:0] y0;
        logic       v1, d1;
        logic [7:0] y1;
        logic [1:0] g;
        logic       cvs, cen;
        logic [7:0] cy;
        logic       bsy, vld, sel;
        int         e0, e1;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic drv(input logic v0, input logic d0, input logic [7:0] y0,
                       input logic v1, input logic d1, input logic [7:0] y1);
        s0_if.vs = v0;
        s0_if.hs = v0;
        s0_if.de = d0;
        s0_if.y  = y0;
        s0_if.cb = y0 ^ 8'h55;
        s0_if.cr = ~y0;
        s1_if.vs = v1;
        s1_if.hs = v1;
        s1_if.de = d1;
        s1_if.y  = y1;
        s1_if.cb = y1 ^ 8'h55;
        s1_if.cr = ~y1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        mask = 2'b11;
        drv(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic idle_ticks(input int n);
        drv(0, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        tv[0]  = '{2'b11, 1, 1, 8'h21, 1, 1, 8'h51, 2'b01, 1, 1, 8'h21, 1, 0, 0, 0, 1};
        tv[1]  = '{2'b11, 1, 1, 8'h22, 1, 1, 8'h52, 2'b01, 1, 1, 8'h22, 1, 0, 0, 0, 1};
        tv[2]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 1, 0, 0, 0, 1};
        tv[3]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 1, 1, 0, 0, 1};
        tv[4]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 1, 1, 0, 0, 1};
        tv[5]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 0, 0, 0, 0, 1};
        tv[6]  = '{2'b11, 1, 1, 8'h23, 1, 1, 8'h53, 2'b10, 1, 1, 8'h53, 1, 0, 0, 1, 1};
        tv[7]  = '{2'b11, 1, 1, 8'h24, 1, 1, 8'h54, 2'b10, 1, 1, 8'h54, 1, 0, 0, 1, 1};
        tv[8]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 1, 0, 0, 1, 1};
        tv[9]  = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 1, 1, 1, 1, 1};
        tv[10] = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 1, 1, 1, 1, 1};
        tv[11] = '{2'b11, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 8'h00, 0, 0, 1, 1, 1};

        // reset state
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cvt_y", cvt_if.y, 0);
        chk("rst_cvt_vs", cvt_if.vs, 0);
        chk("rst_vld", ovld, 0);
        chk("rst_dc0", dc0, 0);
        chk("rst_dc1", dc1, 0);

        // single 20-cycle frame on source 0
        for (int k = 0; k < 20; k++) begin
            drv(1, 1, 8'(k + 10), 0, 0, 8'h00);
            tick();
            chk("f1_grant", grant, 1);
            chk("f1_y", cvt_if.y, k + 10);
            chk("f1_vs", cvt_if.vs, 1);
            chk("f1_en", cvt_if.de, 1);
            chk("f1_vld", ovld, (k >= 3) ? 1 : 0);
            if (k >= 3) chk("f1_sel", osel, 0);
            if (k == 5) chk("f1_cb", cvt_if.cb, 15 ^ 8'h55);
        end
        for (int k = 20; k < 24; k++) begin
            drv(0, 0, 8'h00, 0, 0, 8'h00);
            tick();
            chk("f1_drain_grant", grant, 0);
            chk("f1_drain_busy", busy, (k < 23) ? 1 : 0);
            chk("f1_drain_vld", ovld, (k < 23) ? 1 : 0);
            chk("f1_drain_vs", cvt_if.vs, 0);
        end

        // simultaneous rises: pointer alternates, loser counted
        do_reset();
        for (int i = 0; i < 12; i++) begin
            mask = tv[i].msk;
            drv(tv[i].v0, tv[i].d0, tv[i].y0, tv[i].v1, tv[i].d1, tv[i].y1);
            tick();
            chk($sformatf("tv%0d_grant", i), grant, tv[i].g);
            chk($sformatf("tv%0d_vs", i), cvt_if.vs, tv[i].cvs);
            chk($sformatf("tv%0d_en", i), cvt_if.de, tv[i].cen);
            chk($sformatf("tv%0d_y", i), cvt_if.y, tv[i].cy);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
            chk($sformatf("tv%0d_vld", i), ovld, tv[i].vld);
            if (tv[i].vld) chk($sformatf("tv%0d_sel", i), osel, tv[i].sel);
            chk($sformatf("tv%0d_dc0", i), dc0, tv[i].e0);
            chk($sformatf("tv%0d_dc1", i), dc1, tv[i].e1);
        end

        // source 1 refused during grant and during drain
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drv(c < 6, c < 6, 8'(8'h30 + c), (c == 1) || (c >= 7), 1, 8'h90);
            tick();
            if (c < 6) begin
                chk("busy1_grant", grant, 1);
                chk("busy1_y", cvt_if.y, 8'h30 + c);
            end
            if (c == 1) chk("busy1_dc1_a", dc1, 1);
            if (c == 7) chk("busy1_dc1_b", dc1, 2);
        end
        chk("busy1_idle_grant", grant, 0);
        chk("busy1_idle_y", cvt_if.y, 0);
        chk("busy1_idle_busy", busy, 0);
        chk("busy1_dc0", dc0, 0);
        chk("busy1_dc1", dc1, 2);
        idle_ticks(2);

        // masked source 0, then mask cleared mid-frame of source 1
        do_reset();
        mask = 2'b10;
        for (int c = 0; c < 3; c++) begin
            drv(1, 1, 8'h66, 0, 0, 8'h00);
            tick();
            chk("mask_grant", grant, 0);
            chk("mask_busy", busy, 0);
        end
        chk("mask_dc0", dc0, 0);
        chk("mask_dc1", dc1, 0);
        idle_ticks(1);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) mask = 2'b00;
            drv(0, 0, 8'h00, 1, 1, 8'(8'h70 + c));
            tick();
            chk("mask_s1_grant", grant, 2);
            chk("mask_s1_y", cvt_if.y, 8'h70 + c);
        end
        idle_ticks(1);
        chk("mask_s1_end_grant", grant, 0);
        chk("mask_s1_end_busy", busy, 1);
        idle_ticks(3);
        chk("mask_s1_idle", busy, 0);
        chk("mask_s1_dc1", dc1, 0);

        // reset in mid-frame with vs held high
        do_reset();
        drv(1, 1, 8'h40, 0, 0, 8'h00);
        for (int c = 0; c < 3; c++) tick();
        chk("mr_pre_grant", grant, 1);
        rst = 1'b1;
        tick();
        tick();
        chk("mr_rst_grant", grant, 0);
        chk("mr_rst_y", cvt_if.y, 0);
        chk("mr_rst_vs", cvt_if.vs, 0);
        chk("mr_rst_vld", ovld, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mr_hold_grant", grant, 0);
            chk("mr_hold_vs", cvt_if.vs, 0);
        end
        drv(0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        chk("mr_low_grant", grant, 0);
        drv(1, 1, 8'h41, 0, 0, 8'h00);
        tick();
        chk("mr_regrant", grant, 1);
        chk("mr_regrant_y", cvt_if.y, 8'h41);
        idle_ticks(4);
        chk("mr_end_busy", busy, 0);

        // counter saturation on the 2-bit instance
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drv(1, 1, 8'h60, c % 2 == 1, 1, 8'h99);
            tick();
            chk("sat_grant", grant, 1);
            chk("sat_y", cvt_if.y, 8'h60);
            if (c == 5) begin
                chk("sat_dc1_mid", dc1, 3);
                chk("sat_nc1_mid", nc1, 3);
            end
        end
        chk("sat_dc1", dc1, 5);
        chk("sat_nc1", nc1, 3);
        chk("sat_nc0", nc0, 0);
        idle_ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
